ahb_lite_req_arbiter: RTL
=========================

Name: ahb_lite_req_arbiter

Overview:
Round-robin arbiter and single-transfer sequencer that lets NREQ local requesters share one AHB-Lite master port driving the ahb3liten slave (16-bit HADDR, 32-bit data).
It serialises each request into a NONSEQ address phase followed by a data phase, returns read data and error status to the winning requester, and screens illegal requests before they reach the bus.

Parameters:
NREQ, 2, number of requesters (2..8)
AW, 16, address width
DW, 32, data width

Ports:
HCLK  in  1  bus clock
HRESET  in  1  synchronous active-high reset
req  in  NREQ  per-requester request; held high until the matching done pulse
req_addr  in  NREQ*AW  per-requester byte address, requester i at [i*AW +: AW]
req_write  in  NREQ  1 = write, 0 = read
req_size  in  NREQ*3  per-requester HSIZE encoding
req_wdata  in  NREQ*DW  per-requester write data
gnt  out  NREQ  one-hot; high while the requester owns the transfer
done  out  NREQ  one-cycle completion pulse
err  out  1  valid with done; 1 = HRESP error or local reject
rdata  out  DW  valid with done on reads
HSEL  out  1  slave select
HADDR  out  AW  address
HTRANS  out  2  IDLE = 00, NONSEQ = 10 only
HWRITE  out  1  direction
HSIZE  out  3  transfer size
HBURST  out  3  constant 000 (SINGLE)
HPROT  out  4  constant 0011
HWDATA  out  DW  write data, data phase only
HREADY  in  1  slave HREADYOUT loopback
HRDATA  in  DW  read data
HRESP  in  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset, sampled on the HCLK edge:
  - outputs: gnt = 0, done = 0, err = 0, rdata = 0, HSEL = 0, HTRANS = 00, HADDR = 0, HWRITE = 0, HSIZE = 0, HWDATA = 0.
  - state: FSM = IDLE, round-robin pointer = 0.
  - A reset mid-transfer abandons the transfer; no done pulse is issued.
- FSM states: IDLE, CHECK, ADDR, DATA, RESP.
- IDLE: if any req is set, pick the first set bit searching from the pointer upward with wrap. Latch its index, addr, write, size and wdata, assert gnt, go to CHECK. Later changes on the requester inputs are ignored.
- CHECK: one cycle. The request is illegal if:
  - size > 2, or
  - size == 1 and addr[0] != 0, or
  - size == 2 and addr[1:0] != 0.
  Illegal -> go to RESP with err = 1 and no bus activity. Legal -> go to ADDR.
- ADDR: drive HSEL = 1, HTRANS = 10, HADDR, HWRITE and HSIZE from the latched request.
  - If HREADY = 1, go to DATA on the next edge.
  - If HREADY = 0, hold all address-phase signals stable.
- DATA: drive HTRANS = 00 and HSEL = 0. Drive HWDATA from the latched wdata when writing, otherwise 0.
  - Wait while HREADY = 0.
  - On HREADY = 1: capture rdata = HRDATA (reads only) and err = HRESP, go to RESP.
  - A two-cycle ERROR response (HRESP = 1 with HREADY = 0, then HRESP = 1 with HREADY = 1) completes on the second cycle with err = 1.
- RESP: one cycle.
  - done[idx] = 1, err and rdata valid.
  - gnt deasserts at the end of this cycle.
  - Pointer becomes (idx + 1) mod NREQ; go to IDLE.
- Minimum latency, req rising to done:
  - legal transfer with zero-wait slave: 4 cycles (IDLE, CHECK, ADDR, DATA, then done in RESP).
  - rejected request: 2 cycles.
- Requester rules:
  - A requester must drop req in the cycle after its done pulse. If it keeps req high, that is a new request.
  - If req drops while gnt is high, the transfer still completes and done still pulses.
- Only one transfer is outstanding at a time; HTRANS is never SEQ or BUSY.
- Simultaneous requests are served in round-robin order. Starvation bound: any requester is served within NREQ transfers.
- rdata holds its last value between reads. err is cleared to 0 in every non-RESP cycle.

Test Plan:
- Single write from req0, addr 0x0010, size 2, wdata 0xDEADBEEF, HREADY always 1 -> HTRANS = 10 for one cycle with HADDR = 0x0010 and HWRITE = 1; next cycle HWDATA = 0xDEADBEEF; done[0] 4 cycles after req; err = 0.
- Read from req1, addr 0x0010, after the previous write -> rdata = 0xDEADBEEF with done[1]; HWDATA = 0 during the data phase.
- req0 and req1 both held for 4 transfers from reset -> grant order 0, 1, 0, 1; never the same requester twice in a row while the other is pending.
- Slave inserts 3 wait states in the data phase of a read -> HADDR, HTRANS and HSEL not re-driven during the waits; done arrives 3 cycles later than the zero-wait case; rdata valid.
- Misaligned req0 (addr 0x0002, size 2) and req0 with size 3 -> no HSEL/NONSEQ cycle; done[0] with err = 1, 2 cycles after req.
- Slave two-cycle ERROR response on a write -> done with err = 1 on the HREADY = 1 cycle. Reset asserted during the data phase of a separate transfer -> all outputs reach reset values on the next edge and no done pulse appears.

Source files
------------

// File: rtl/ahb_lite_req_arbiter.sv
// Round-robin arbiter that serialises NREQ local requesters into single
// NONSEQ transfers on one AHB-Lite master port, screening illegal requests.
module ahb_lite_req_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 16,
  parameter int DW   = 32
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*3-1:0]    req_size,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [DW-1:0]        rdata,
  output logic                 HSEL,
  output logic [AW-1:0]        HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic [3:0]           HPROT,
  output logic [DW-1:0]        HWDATA,
  input  logic                 HREADY,
  input  logic [DW-1:0]        HRDATA,
  input  logic                 HRESP,
  output logic [2:0]           dbg_state_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d, ptr_q, ptr_d, pick_idx;
  logic            pick_found;
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [2:0]      size_q, size_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            illegal;
  logic [NREQ-1:0] idx_onehot;

  // First set request at or above the pointer, wrapping round.
  always_comb begin
    int j;
    j          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!pick_found && req[j]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(j);
      end
    end
  end

  assign illegal = (size_q > 3'd2) ||
                   ((size_q == 3'd1) && addr_q[0]) ||
                   ((size_q == 3'd2) && (addr_q[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          idx_d   = pick_idx;
          addr_d  = req_addr[int'(pick_idx)*AW +: AW];
          write_d = req_write[pick_idx];
          size_d  = req_size[int'(pick_idx)*3 +: 3];
          wdata_d = req_wdata[int'(pick_idx)*DW +: DW];
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (illegal) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (HREADY) state_d = S_DATA;
      end
      S_DATA: begin
        if (HREADY) begin
          err_d = HRESP;
          if (!write_q) rdata_d = HRDATA;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        ptr_d   = (idx_q == IW'(NREQ-1)) ? '0 : idx_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Bus signals are decoded from state so they are idle whenever not in use.
  assign idx_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << idx_q;
  assign gnt         = (state_q != S_IDLE) ? idx_onehot : '0;
  assign done        = (state_q == S_RESP) ? idx_onehot : '0;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign HSEL        = (state_q == S_ADDR);
  assign HTRANS      = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign HADDR       = (state_q == S_ADDR) ? addr_q : '0;
  assign HWRITE      = (state_q == S_ADDR) ? write_q : 1'b0;
  assign HSIZE       = (state_q == S_ADDR) ? size_q : 3'd0;
  assign HWDATA      = ((state_q == S_DATA) && write_q) ? wdata_q : '0;
  assign HBURST      = 3'b000;
  assign HPROT       = 4'b0011;
  assign dbg_state_o = state_q;

endmodule
